// File: rtl/div_pkg.sv
// ============================================================================
// Module      : div_pkg
// Description : Shared widths, iteration count, error code and FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

    localparam int              BCD_W        = 12;
    localparam int              CONV_ITERS   = 8;
    localparam logic [11:0]     ERR_CODE_DEF = 12'hEEE;

    localparam logic [1:0]      ST_IDLE      = 2'd0;
    localparam logic [1:0]      ST_CONV      = 2'd1;
    localparam logic [1:0]      ST_DONE      = 2'd2;

    typedef enum logic [1:0] {
        E_IDLE = ST_IDLE,
        E_CONV = ST_CONV,
        E_DONE = ST_DONE
    } state_e;

endpackage : div_pkg

`default_nettype wire

// File: rtl/bcd_dabble_step.sv
// ============================================================================
// Module      : bcd_dabble_step
// Description : One combinational double-dabble iteration (adjust then shift).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_dabble_step
    import div_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_i,
    input  logic [7:0]       bin_i,
    output logic [BCD_W-1:0] bcd_o,
    output logic [7:0]       bin_o
);

    logic [BCD_W-1:0] w_adj;
    logic             w_msb_unused;

    for (genvar d = 0; d < BCD_W / 4; d++) begin : g_digit
        assign w_adj[4*d +: 4] = (bcd_i[4*d +: 4] >= 4'd5) ? (bcd_i[4*d +: 4] + 4'd3)
                                                             : bcd_i[4*d +: 4];
    end

    // Hundreds digit never exceeds 2 for an 8-bit operand, so its MSB is always 0.
    assign w_msb_unused = w_adj[BCD_W-1];
    assign bcd_o        = {w_adj[BCD_W-2:0], bin_i[7]};
    assign bin_o        = {bin_i[6:0], 1'b0};

endmodule : bcd_dabble_step

`default_nettype wire

// File: rtl/div_bcd_conv.sv
// ============================================================================
// Module      : div_bcd_conv
// Description : Converts divider quotient/remainder to 3-digit BCD.
//               Define DIV_BCD_REM_EN to build the remainder conversion path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_bcd_conv
    import div_pkg::*;
#(
    parameter logic [BCD_W-1:0] ERR_CODE = ERR_CODE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       quo,
    input  logic [7:0]       rem,
    input  logic             div_err,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] quo_bcd,
    output logic [BCD_W-1:0] rem_bcd,
    output logic             err_out
);

    localparam logic [3:0] CNT_INIT = 4'(CONV_ITERS);

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q;
    logic [7:0]       quo_sh_q;
    logic [BCD_W-1:0] quo_acc_q;
    logic [BCD_W-1:0] quo_bcd_q;
    logic             err_q;
    logic [BCD_W-1:0] w_quo_bcd;
    logic [7:0]       w_quo_bin;
    logic             w_start_ok;
    logic             w_last;

    assign w_start_ok = (state_q == ST_IDLE) && start;
    assign w_last     = (state_q == ST_CONV) && (cnt_q == 4'd1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = div_err ? ST_DONE : ST_CONV;
            ST_CONV: if (cnt_q == 4'd1) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    bcd_dabble_step u_quo_step (
        .bcd_i (quo_acc_q),
        .bin_i (quo_sh_q),
        .bcd_o (w_quo_bcd),
        .bin_o (w_quo_bin)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            quo_sh_q  <= '0;
            quo_acc_q <= '0;
            quo_bcd_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (w_start_ok) begin
                quo_sh_q  <= quo;
                quo_acc_q <= '0;
                cnt_q     <= CNT_INIT;
                if (div_err) begin
                    quo_bcd_q <= ERR_CODE;
                    err_q     <= 1'b1;
                end
            end else if (state_q == ST_CONV) begin
                quo_sh_q  <= w_quo_bin;
                quo_acc_q <= w_quo_bcd;
                cnt_q     <= cnt_q - 4'd1;
                if (w_last) begin
                    quo_bcd_q <= w_quo_bcd;
                    err_q     <= 1'b0;
                end
            end
        end
    end

`ifdef DIV_BCD_REM_EN
    logic [7:0]       rem_sh_q;
    logic [BCD_W-1:0] rem_acc_q;
    logic [BCD_W-1:0] rem_bcd_q;
    logic [BCD_W-1:0] w_rem_bcd;
    logic [7:0]       w_rem_bin;

    bcd_dabble_step u_rem_step (
        .bcd_i (rem_acc_q),
        .bin_i (rem_sh_q),
        .bcd_o (w_rem_bcd),
        .bin_o (w_rem_bin)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_sh_q  <= '0;
            rem_acc_q <= '0;
            rem_bcd_q <= '0;
        end else if (w_start_ok) begin
            rem_sh_q  <= rem;
            rem_acc_q <= '0;
            if (div_err) rem_bcd_q <= ERR_CODE;
        end else if (state_q == ST_CONV) begin
            rem_sh_q  <= w_rem_bin;
            rem_acc_q <= w_rem_bcd;
            if (w_last) rem_bcd_q <= w_rem_bcd;
        end
    end

    assign rem_bcd = rem_bcd_q;
`else
    logic w_rem_unused;
    assign w_rem_unused = ^rem;
    assign rem_bcd      = '0;
`endif

    assign busy    = (state_q == ST_CONV) || (state_q == ST_DONE);
    assign done    = (state_q == ST_DONE);
    assign quo_bcd = quo_bcd_q;
    assign err_out = err_q;

endmodule : div_bcd_conv

`default_nettype wire

// File: doc/div_bcd_conv.md
DIV_BCD_CONV -- requirements
Module: div_bcd_conv

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset, exactly as follows.
REQ-002 Parameter ERR_CODE SHALL default to 12'hEEE and is the BCD pattern presented on both result outputs on a divider error.
REQ-003 Port clk, input, 1: rising-edge clock for all state.
REQ-004 Port rst, input, 1: synchronous active-high reset.
REQ-005 Port start, input, 1: request to convert the divider result.
REQ-006 Port quo, input, 8: unsigned divider quotient.
REQ-007 Port rem, input, 8: unsigned divider remainder.
REQ-008 Port div_err, input, 1: divider divide-by-zero flag.
REQ-009 Port busy, output, 1: conversion in progress.
REQ-010 Port done, output, 1: one-cycle pulse marking that results are valid.
REQ-011 Port quo_bcd, output, 12: three BCD digits of quo, hundreds in [11:8].
REQ-012 Port rem_bcd, output, 12: three BCD digits of rem.
REQ-013 Port err_out, output, 1: registered copy of div_err captured at start.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, CONV and DONE.
REQ-015 In IDLE with start=1, the block SHALL capture quo, rem and div_err on that edge, clear the BCD accumulators, load an iteration counter with 8, and go to CONV, or go to DONE if div_err=1.
REQ-016 Each CONV cycle SHALL perform one double-dabble step per operand: add 3 to every BCD digit >= 5, then shift left 1 with the operand MSB entering the BCD LSB; the counter decrements by 1.
REQ-017 After the step with counter=1, the FSM SHALL go to DONE; conversion therefore takes exactly 8 CONV cycles.
REQ-018 Latency: with start sampled in cycle 0, done SHALL be 1 in cycle 9 on success, or in cycle 1 on error.
REQ-019 In DONE, done=1 for exactly one cycle and the FSM SHALL return to IDLE unconditionally.
REQ-020 busy SHALL be 1 exactly while in CONV or DONE.
REQ-021 quo_bcd, rem_bcd and err_out SHALL be registered, update only on entry to DONE, and hold until the next DONE.
REQ-022 On the error path, quo_bcd and rem_bcd SHALL both be ERR_CODE and err_out=1; otherwise err_out=0.
REQ-023 start asserted while busy=1 SHALL be ignored and SHALL NOT be queued; input changes during CONV have no effect.
REQ-024 start asserted in the DONE cycle SHALL be ignored; a new conversion needs start in IDLE.
REQ-025 Every BCD digit produced SHALL be in 0..9; maximum output is 12'h255.

Reset
REQ-026 With rst=1 at a clock edge, the FSM SHALL go to IDLE, the counter to 0, and busy, done, err_out, quo_bcd and rem_bcd to 0, including in the middle of a conversion.
REQ-027 rst SHALL take priority over start in the same cycle.

Configuration
REQ-028 Macro DIV_BCD_REM_EN: when defined, remainder conversion SHALL be implemented as above.
REQ-029 When DIV_BCD_REM_EN is not defined, rem_bcd SHALL be constant 0, including on the error path, no remainder datapath is built, and timing is unchanged.

Structure
REQ-030 The shared package div_pkg SHALL hold the FSM state enum, BCD_W=12, CONV_ITERS=8, and the default error code.
REQ-031 The combinational sub-module bcd_dabble_step (12-bit BCD in, 8-bit operand in; shifted BCD and operand out) SHALL be instantiated once per converted operand.

Verification
REQ-032 quo=255, rem=0, start in cycle 0 -> done in cycle 9, quo_bcd=12'h255, rem_bcd=12'h000, err_out=0.
REQ-033 quo=100, rem=7 -> quo_bcd=12'h100, rem_bcd=12'h007; busy=1 in cycles 1-9.
REQ-034 div_err=1, quo=0 -> done in cycle 1, quo_bcd=rem_bcd=12'hEEE, err_out=1.
REQ-035 quo=42 started, start re-pulsed in cycle 4 with quo=99 -> single done in cycle 9 with quo_bcd=12'h042, and no second done.
REQ-036 rst asserted in cycle 5 of a conversion -> the next cycle shows IDLE with busy=0, done=0 and all outputs 0; a fresh start with quo=9, rem=3 then yields 12'h009 and 12'h003.
REQ-037 Build without DIV_BCD_REM_EN, rem=199 -> rem_bcd=0 and quo conversion is unchanged.
